// File: rtl/rename_regfile_if.sv
// rename_regfile_if
// Groups the dispatch, read, commit and checkpoint signals of rename_regfile.
//   master : pipeline side, drives rename/commit/checkpoint controls and read
//            addresses, and receives read results and checkpoint status
//   slave  : register file side, the mirror image of master
// Parameters mirror the register file: DATA_W, TAG_W, NUM_RD, NUM_CKPT.
interface rename_regfile_if #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_RD   = 2,
    parameter int NUM_CKPT = 4
);
    localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic                     rename_en;
    logic [4:0]               rename_rd;
    logic [TAG_W-1:0]         rename_tag;
    logic [NUM_RD*5-1:0]      rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_RD*TAG_W-1:0]  rd_tag;
    logic                     commit_en;
    logic [4:0]               commit_rd;
    logic [TAG_W-1:0]         commit_tag;
    logic [DATA_W-1:0]        commit_data;
    logic                     ckpt_take;
    logic [CW-1:0]            ckpt_id;
    logic                     ckpt_full;
    logic                     ckpt_release;
    logic                     restore_en;
    logic [CW-1:0]            restore_id;
    logic                     flush;

    modport master (
        output rename_en, rename_rd, rename_tag, rd_addr,
        output commit_en, commit_rd, commit_tag, commit_data,
        output ckpt_take, ckpt_release, restore_en, restore_id, flush,
        input  rd_data, rd_busy, rd_tag, ckpt_id, ckpt_full
    );

    modport slave (
        input  rename_en, rename_rd, rename_tag, rd_addr,
        input  commit_en, commit_rd, commit_tag, commit_data,
        input  ckpt_take, ckpt_release, restore_en, restore_id, flush,
        output rd_data, rd_busy, rd_tag, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile
// Architectural register file with rename (busy/tag) state for an
// out-of-order core. Each register holds a value, a busy bit and the ROB tag
// of its pending producer. Commits write values and clear busy only when the
// committing tag is still the newest producer. Branch checkpoints snapshot
// the busy/tag tables into a circular FIFO of slots for mispredict recovery.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - rename_regfile_if.slave: rename, read ports, commit, checkpoint
//          take/release/restore and flush
// Build option:
//   RF_CKPT_EN - when defined, checkpoint slots are implemented; otherwise
//                ckpt_id/ckpt_full read 0, take/release are ignored and
//                restore_en clears all busy bits like a flush.
module rename_regfile #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_RD   = 2,
    parameter int NUM_CKPT = 4
) (
    input  logic            clk,
    input  logic            rst,
    rename_regfile_if.slave bus
);
    localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic [DATA_W-1:0]   val_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d, busyNorm;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [TAG_W-1:0]    tagNorm [NUM_REGS];
    logic                commitHit;

    // Commits to x0 are dropped everywhere.
    assign commitHit = bus.commit_en && (bus.commit_rd != 5'd0);

    // Read ports see pre-edge state plus a commit bypass; a bypassed commit
    // only drops busy when it is still the register's newest producer.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        bus.rd_tag  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_addr[p*5 +: 5] != 5'd0) begin
                bus.rd_data[p*DATA_W +: DATA_W] = val_q[bus.rd_addr[p*5 +: 5]];
                bus.rd_busy[p]                  = busy_q[bus.rd_addr[p*5 +: 5]];
                bus.rd_tag[p*TAG_W +: TAG_W]    = tag_q[bus.rd_addr[p*5 +: 5]];
                if (commitHit && bus.commit_rd == bus.rd_addr[p*5 +: 5]) begin
                    bus.rd_data[p*DATA_W +: DATA_W] = bus.commit_data;
                    if (tag_q[bus.rd_addr[p*5 +: 5]] == bus.commit_tag) begin
                        bus.rd_busy[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Normal-path next busy/tag tables: commit clear first, then rename, so a
    // same-cycle rename of the committed register keeps it busy.
    always_comb begin
        busyNorm = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            tagNorm[r] = tag_q[r];
        end
        if (commitHit && busy_q[bus.commit_rd] && tag_q[bus.commit_rd] == bus.commit_tag) begin
            busyNorm[bus.commit_rd] = 1'b0;
        end
        if (bus.rename_en && bus.rename_rd != 5'd0) begin
            busyNorm[bus.rename_rd] = 1'b1;
            tagNorm[bus.rename_rd]  = bus.rename_tag;
        end
    end

`ifdef RF_CKPT_EN
    localparam logic [CW:0] CNT_FULL = (CW+1)'(NUM_CKPT);
    localparam logic [CW:0] CNT_ONE  = (CW+1)'(1);

    logic [CW-1:0]       head_q, head_d, tail_q, tail_d, restoreOfs;
    logic [CW:0]         count_q, count_d;
    logic [NUM_REGS-1:0] slotBusy_q [NUM_CKPT];
    logic [NUM_REGS-1:0] slotBusy_d [NUM_CKPT];
    logic [TAG_W-1:0]    slotTag_q [NUM_CKPT][NUM_REGS];
    logic [TAG_W-1:0]    slotTag_d [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] slotLive;
    logic                restoreOk, doTake, doRelease;

    // A slot is live when its distance from head (mod NUM_CKPT) is below count.
    always_comb begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            slotLive[s] = {1'b0, CW'(s) - head_q} < count_q;
        end
        restoreOfs = bus.restore_id - head_q;
        restoreOk  = bus.restore_en && ({1'b0, restoreOfs} < count_q);
        doTake     = bus.ckpt_take && (count_q != CNT_FULL);
        doRelease  = bus.ckpt_release && (count_q != '0);
    end

    // Next state with priority flush > restore > rename/take/release. Live
    // slots always see the commit clear so a later restore never resurrects a
    // producer that has already written back.
    always_comb begin
        busy_d  = busyNorm;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            tag_d[r] = tagNorm[r];
        end
        for (int s = 0; s < NUM_CKPT; s++) begin
            slotBusy_d[s] = slotBusy_q[s];
            for (int r = 0; r < NUM_REGS; r++) begin
                slotTag_d[s][r] = slotTag_q[s][r];
            end
            if (slotLive[s] && commitHit && slotBusy_q[s][bus.commit_rd]
                && slotTag_q[s][bus.commit_rd] == bus.commit_tag) begin
                slotBusy_d[s][bus.commit_rd] = 1'b0;
            end
        end
        if (bus.flush) begin
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_d[r] = tag_q[r];
            end
        end else if (restoreOk) begin
            busy_d  = slotBusy_d[bus.restore_id];
            tail_d  = bus.restore_id;
            count_d = {1'b0, restoreOfs};
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_d[r] = slotTag_q[bus.restore_id][r];
            end
        end else begin
            if (doTake) begin
                slotBusy_d[tail_q] = busyNorm;
                for (int r = 0; r < NUM_REGS; r++) begin
                    slotTag_d[tail_q][r] = tagNorm[r];
                end
                tail_d = tail_q + CW'(1);
            end
            if (doRelease) begin
                head_d = head_q + CW'(1);
            end
            if (doTake && !doRelease) begin
                count_d = count_q + CNT_ONE;
            end else if (!doTake && doRelease) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Checkpoint storage and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                slotBusy_q[s] <= '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    slotTag_q[s][r] <= '0;
                end
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int s = 0; s < NUM_CKPT; s++) begin
                slotBusy_q[s] <= slotBusy_d[s];
                for (int r = 0; r < NUM_REGS; r++) begin
                    slotTag_q[s][r] <= slotTag_d[s][r];
                end
            end
        end
    end

    assign bus.ckpt_id   = tail_q;
    assign bus.ckpt_full = (count_q == CNT_FULL);
`else
    logic unusedCkptInputs;

    // Without checkpoints a restore can only recover by dropping all pending
    // producers, exactly like a flush.
    always_comb begin
        busy_d = busyNorm;
        for (int r = 0; r < NUM_REGS; r++) begin
            tag_d[r] = tagNorm[r];
        end
        if (bus.flush || bus.restore_en) begin
            busy_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_d[r] = tag_q[r];
            end
        end
    end

    assign unusedCkptInputs = ^{bus.ckpt_take, bus.ckpt_release, bus.restore_id};
    assign bus.ckpt_id      = CW'(0);
    assign bus.ckpt_full    = 1'b0;
`endif

    // Register values, busy bits and tags. The commit value write is never
    // suppressed by flush or restore.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
            if (commitHit) begin
                val_q[bus.commit_rd] <= bus.commit_data;
            end
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile
// Self-checking bench for rename_regfile: directed scenarios plus a random
// run compared against a behavioural model (per-register arrays and a queue
// of live checkpoint slot ids). Expectations follow RF_CKPT_EN.
module tb_rename_regfile;
    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int NRD = 2;
    localparam int NC  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rename_regfile_if #(.DATA_W(DW), .TAG_W(TW), .NUM_RD(NRD), .NUM_CKPT(NC)) bus ();

    rename_regfile #(.NUM_REGS(NR), .DATA_W(DW), .TAG_W(TW), .NUM_RD(NRD), .NUM_CKPT(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mVal [NR];
    bit            mBusy [NR];
    logic [TW-1:0] mTag [NR];
`ifdef RF_CKPT_EN
    bit            sBusy [NC][NR];
    logic [TW-1:0] sTag [NC][NR];
    int            liveQ[$];
    int            nextId;
`endif

    task automatic modelReset();
        for (int r = 0; r < NR; r++) begin
            mVal[r] = '0;
            mBusy[r] = 1'b0;
            mTag[r] = '0;
        end
`ifdef RF_CKPT_EN
        liveQ.delete();
        nextId = 0;
`endif
    endtask

    // Expected read result for one address given the current bus inputs
    function automatic void modelRead(input logic [4:0] a, output logic [DW-1:0] d,
                                      output logic b, output logic [TW-1:0] t);
        d = '0;
        b = 1'b0;
        t = '0;
        if (a != 5'd0) begin
            d = mVal[a];
            b = mBusy[a];
            t = mTag[a];
            if (bus.commit_en && bus.commit_rd == a) begin
                d = bus.commit_data;
                if (mTag[a] == bus.commit_tag) b = 1'b0;
            end
        end
    endfunction

    function automatic void modelCkpt(output logic [1:0] id, output logic full);
`ifdef RF_CKPT_EN
        id   = 2'(nextId);
        full = (liveQ.size() == NC);
`else
        id   = 2'd0;
        full = 1'b0;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs currently on the bus
    task automatic modelUpdate();
        bit ch;
        int cr;
        int pos;
        ch  = bus.commit_en && bus.commit_rd != 5'd0;
        cr  = int'(bus.commit_rd);
        pos = -1;
        if (ch) mVal[cr] = bus.commit_data;
`ifdef RF_CKPT_EN
        foreach (liveQ[k]) begin
            if (ch && sBusy[liveQ[k]][cr] && sTag[liveQ[k]][cr] == bus.commit_tag)
                sBusy[liveQ[k]][cr] = 1'b0;
            if (liveQ[k] == int'(bus.restore_id)) pos = k;
        end
        if (bus.flush) begin
            for (int r = 0; r < NR; r++) mBusy[r] = 1'b0;
            liveQ.delete();
            nextId = 0;
        end else if (bus.restore_en && pos >= 0) begin
            for (int r = 0; r < NR; r++) begin
                mBusy[r] = sBusy[liveQ[pos]][r];
                mTag[r]  = sTag[liveQ[pos]][r];
            end
            while (liveQ.size() > pos) void'(liveQ.pop_back());
            nextId = int'(bus.restore_id);
        end else begin
            bit full;
            bit some;
            full = (liveQ.size() == NC);
            some = (liveQ.size() > 0);
            if (ch && mBusy[cr] && mTag[cr] == bus.commit_tag) mBusy[cr] = 1'b0;
            if (bus.rename_en && bus.rename_rd != 5'd0) begin
                mBusy[bus.rename_rd] = 1'b1;
                mTag[bus.rename_rd]  = bus.rename_tag;
            end
            if (bus.ckpt_take && !full) begin
                for (int r = 0; r < NR; r++) begin
                    sBusy[nextId][r] = mBusy[r];
                    sTag[nextId][r]  = mTag[r];
                end
                liveQ.push_back(nextId);
                nextId = (nextId + 1) % NC;
            end
            if (bus.ckpt_release && some) void'(liveQ.pop_front());
        end
`else
        if (bus.flush || bus.restore_en) begin
            for (int r = 0; r < NR; r++) mBusy[r] = 1'b0;
        end else begin
            if (ch && mBusy[cr] && mTag[cr] == bus.commit_tag) mBusy[cr] = 1'b0;
            if (bus.rename_en && bus.rename_rd != 5'd0) begin
                mBusy[bus.rename_rd] = 1'b1;
                mTag[bus.rename_rd]  = bus.rename_tag;
            end
        end
        if (pos != -1) pos = -1;
`endif
    endtask

    task automatic setIdle();
        bus.rename_en    = 1'b0;
        bus.rename_rd    = '0;
        bus.rename_tag   = '0;
        bus.rd_addr      = '0;
        bus.commit_en    = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_tag   = '0;
        bus.commit_data  = '0;
        bus.ckpt_take    = 1'b0;
        bus.ckpt_release = 1'b0;
        bus.restore_en   = 1'b0;
        bus.restore_id   = '0;
        bus.flush        = 1'b0;
    endtask

    // One clock edge: model follows the DUT, then return at the falling edge
    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic doFlush();
        setIdle();
        bus.flush = 1'b1;
        tick();
        setIdle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        setIdle();
        bus.rd_addr = {5'd3, 5'd5};
        #1;
        checks++;
        if (bus.rd_busy !== 2'b00 || bus.rd_tag !== '0 || bus.rd_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_reads: busy %b tag %h data %h, expected all zero",
                     bus.rd_busy, bus.rd_tag, bus.rd_data);
        end
        checks++;
        if (bus.ckpt_id !== 2'd0 || bus.ckpt_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ckpt: id %0d full %b, expected 0 0", bus.ckpt_id, bus.ckpt_full);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_commit_bypass();
        doFlush();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd5; bus.rename_tag = 4'd3;
        tick();
        setIdle();
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[3:0] !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rename_x5: busy %b tag %0d, expected 1 3", bus.rd_busy[0], bus.rd_tag[3:0]);
        end
        tick();
        bus.commit_en = 1'b1; bus.commit_rd = 5'd5; bus.commit_tag = 4'd3; bus.commit_data = 32'hDEAD;
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[31:0] !== 32'hDEAD) begin
            errors++;
            $display("[TB] FAIL bypass_x5: busy %b data %h, expected 0 0000dead", bus.rd_busy[0], bus.rd_data[31:0]);
        end
        tick();
        setIdle();
        bus.rd_addr = {5'd5, 5'd0};
        #1;
        checks++;
        if (bus.rd_busy[1] !== 1'b0 || bus.rd_data[63:32] !== 32'hDEAD) begin
            errors++;
            $display("[TB] FAIL committed_x5: busy %b data %h, expected 0 0000dead", bus.rd_busy[1], bus.rd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_younger_rename();
        doFlush();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd7; bus.rename_tag = 4'd2;
        tick();
        bus.rename_tag = 4'd6;
        tick();
        setIdle();
        bus.commit_en = 1'b1; bus.commit_rd = 5'd7; bus.commit_tag = 4'd2; bus.commit_data = 32'h11;
        tick();
        setIdle();
        bus.rd_addr = {5'd7, 5'd0};
        #1;
        checks++;
        if (bus.rd_data[63:32] !== 32'h11 || bus.rd_busy[1] !== 1'b1 || bus.rd_tag[7:4] !== 4'd6) begin
            errors++;
            $display("[TB] FAIL younger_x7: data %h busy %b tag %0d, expected 00000011 1 6",
                     bus.rd_data[63:32], bus.rd_busy[1], bus.rd_tag[7:4]);
        end
        checks++;
        if (bus.rd_data[31:0] !== '0 || bus.rd_busy[0] !== 1'b0 || bus.rd_tag[3:0] !== '0) begin
            errors++;
            $display("[TB] FAIL read_x0: data %h busy %b tag %0d, expected 0 0 0",
                     bus.rd_data[31:0], bus.rd_busy[0], bus.rd_tag[3:0]);
        end
        tick();
    endtask

    task automatic test_restore();
        logic       expBusy;
        logic [3:0] expTag;
`ifdef RF_CKPT_EN
        expBusy = 1'b1; expTag = 4'd1;
`else
        expBusy = 1'b0; expTag = 4'd4;
`endif
        doFlush();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd3; bus.rename_tag = 4'd1;
        tick();
        setIdle();
        bus.ckpt_take = 1'b1;
        #1;
        checks++;
        if (bus.ckpt_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL take_id: got %0d expected 0", bus.ckpt_id);
        end
        tick();
        setIdle();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd3; bus.rename_tag = 4'd4;
        tick();
        setIdle();
        bus.restore_en = 1'b1; bus.restore_id = 2'd0;
        tick();
        setIdle();
        bus.rd_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (bus.rd_busy[0] !== expBusy || bus.rd_tag[3:0] !== expTag) begin
            errors++;
            $display("[TB] FAIL restore_x3: busy %b tag %0d, expected %b %0d",
                     bus.rd_busy[0], bus.rd_tag[3:0], expBusy, expTag);
        end
        checks++;
        if (bus.ckpt_id !== 2'd0 || bus.ckpt_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restore_ptr: id %0d full %b, expected 0 0", bus.ckpt_id, bus.ckpt_full);
        end
    endtask

    // Continues from the empty FIFO left by test_restore
    task automatic test_ckpt_full();
        logic [1:0] expId;
        logic       fullNow;
`ifdef RF_CKPT_EN
        fullNow = 1'b1;
`else
        fullNow = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            setIdle();
            bus.ckpt_take = 1'b1;
            bus.rename_en = 1'b1; bus.rename_rd = 5'(10 + i); bus.rename_tag = 4'(i);
            #1;
`ifdef RF_CKPT_EN
            expId = 2'(i);
`else
            expId = 2'd0;
`endif
            checks++;
            if (bus.ckpt_id !== expId || bus.ckpt_full !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fill_%0d: id %0d full %b, expected %0d 0", i, bus.ckpt_id, bus.ckpt_full, expId);
            end
            tick();
        end
        setIdle();
        #1;
        checks++;
        if (bus.ckpt_full !== fullNow || bus.ckpt_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL full: full %b id %0d, expected %b 0", bus.ckpt_full, bus.ckpt_id, fullNow);
        end
        bus.ckpt_take = 1'b1;
        tick();
        setIdle();
        #1;
        checks++;
        if (bus.ckpt_full !== fullNow || bus.ckpt_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL take_when_full: full %b id %0d, expected %b 0", bus.ckpt_full, bus.ckpt_id, fullNow);
        end
        bus.ckpt_release = 1'b1;
        tick();
        setIdle();
        #1;
        checks++;
        if (bus.ckpt_full !== 1'b0 || bus.ckpt_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL release: full %b id %0d, expected 0 0", bus.ckpt_full, bus.ckpt_id);
        end
    endtask

    task automatic test_flush_restore();
        doFlush();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd9; bus.rename_tag = 4'd5;
        tick();
        setIdle();
        bus.ckpt_take = 1'b1;
        tick();
        setIdle();
        bus.commit_en = 1'b1; bus.commit_rd = 5'd9; bus.commit_tag = 4'd5; bus.commit_data = 32'h99;
        tick();
        setIdle();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd9; bus.rename_tag = 4'd7;
        tick();
        setIdle();
        bus.restore_en = 1'b1; bus.restore_id = 2'd0;
        tick();
        setIdle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[31:0] !== 32'h99) begin
            errors++;
            $display("[TB] FAIL restore_cleared_x9: busy %b data %h, expected 0 00000099", bus.rd_busy[0], bus.rd_data[31:0]);
        end
        bus.rename_en = 1'b1; bus.rename_rd = 5'd4; bus.rename_tag = 4'd2;
        tick();
        setIdle();
        bus.flush = 1'b1;
        bus.rename_en = 1'b1; bus.rename_rd = 5'd6; bus.rename_tag = 4'd3;
        tick();
        setIdle();
        bus.rd_addr = {5'd6, 5'd4};
        #1;
        checks++;
        if (bus.rd_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_busy: busy %b, expected 00", bus.rd_busy);
        end
        bus.rename_en = 1'b1; bus.rename_rd = 5'd0; bus.rename_tag = 4'd9;
        bus.commit_en = 1'b1; bus.commit_rd = 5'd0; bus.commit_data = 32'hFFFF;
        bus.rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== 2'b00 || bus.rd_tag !== '0) begin
            errors++;
            $display("[TB] FAIL x0_same_cycle: data %h busy %b tag %h, expected 0", bus.rd_data, bus.rd_busy, bus.rd_tag);
        end
        tick();
        setIdle();
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== 2'b00 || bus.rd_tag !== '0) begin
            errors++;
            $display("[TB] FAIL x0_after: data %h busy %b tag %h, expected 0", bus.rd_data, bus.rd_busy, bus.rd_tag);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] eD;
        logic          eB;
        logic [TW-1:0] eT;
        logic [1:0]    eId;
        logic          eFull;
        for (int c = 0; c < 600; c++) begin
            setIdle();
            bus.rename_en    = ($urandom_range(0, 1) == 1);
            bus.rename_rd    = 5'($urandom_range(0, 7));
            bus.rename_tag   = 4'($urandom);
            bus.commit_en    = ($urandom_range(0, 1) == 1);
            bus.commit_rd    = 5'($urandom_range(0, 7));
            bus.commit_tag   = ($urandom_range(0, 9) < 7) ? mTag[bus.commit_rd] : 4'($urandom);
            bus.commit_data  = $urandom;
            bus.ckpt_take    = ($urandom_range(0, 3) == 0);
            bus.ckpt_release = ($urandom_range(0, 4) == 0);
            bus.restore_en   = ($urandom_range(0, 11) == 0);
            bus.restore_id   = 2'($urandom);
            bus.flush        = ($urandom_range(0, 29) == 0);
            bus.rd_addr[4:0] = 5'($urandom_range(0, 9));
            bus.rd_addr[9:5] = ($urandom_range(0, 1) == 1) ? bus.commit_rd : 5'($urandom);
            #1;
            for (int p = 0; p < NRD; p++) begin
                modelRead(bus.rd_addr[p*5 +: 5], eD, eB, eT);
                checks++;
                if (bus.rd_data[p*DW +: DW] !== eD || bus.rd_busy[p] !== eB || bus.rd_tag[p*TW +: TW] !== eT) begin
                    errors++;
                    $display("[TB] FAIL random_read cycle %0d port %0d x%0d: data %h busy %b tag %0d, expected %h %b %0d",
                             c, p, bus.rd_addr[p*5 +: 5], bus.rd_data[p*DW +: DW], bus.rd_busy[p],
                             bus.rd_tag[p*TW +: TW], eD, eB, eT);
                end
            end
            modelCkpt(eId, eFull);
            checks++;
            if (bus.ckpt_id !== eId || bus.ckpt_full !== eFull) begin
                errors++;
                $display("[TB] FAIL random_ckpt cycle %0d: id %0d full %b, expected %0d %b",
                         c, bus.ckpt_id, bus.ckpt_full, eId, eFull);
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        setIdle();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd2; bus.rename_tag = 4'd8;
        bus.commit_en = 1'b1; bus.commit_rd = 5'd2; bus.commit_data = 32'h1234;
        bus.ckpt_take = 1'b1;
        tick();
        setIdle();
        #2;
        rst = 1'b0;
        bus.rd_addr = {5'd2, 5'd2};
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== 2'b00 || bus.rd_tag !== '0
            || bus.ckpt_id !== 2'd0 || bus.ckpt_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_reset: data %h busy %b tag %h id %0d full %b, expected all 0",
                     bus.rd_data, bus.rd_busy, bus.rd_tag, bus.ckpt_id, bus.ckpt_full);
        end
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        bus.rename_en = 1'b1; bus.rename_rd = 5'd2; bus.rename_tag = 4'd1;
        tick();
        setIdle();
        bus.rd_addr = {5'd0, 5'd2};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_tag[3:0] !== 4'd1 || bus.rd_data[31:0] !== '0) begin
            errors++;
            $display("[TB] FAIL resume_after_reset: busy %b tag %0d data %h, expected 1 1 0",
                     bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_data[31:0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_commit_bypass();
        test_younger_rename();
        test_restore();
        test_ckpt_full();
        test_flush_restore();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL provide parameters: NUM_REGS, default 32, number of architectural registers (x0 hard-wired zero); DATA_W, default 32, register data width; TAG_W, default 4, ROB tag width; NUM_RD, default 2, number of source read ports; NUM_CKPT, default 4, rename-table checkpoint slots (power of two).
REQ-002 SHALL provide ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-low; rename_en  in  1  dispatch renames rename_rd; rename_rd  in  5  destination register; rename_tag  in  TAG_W  ROB tag of dispatching instruction; rd_addr  in  NUM_RD*5  source register per port; rd_data  out  NUM_RD*DATA_W  value per port; rd_busy  out  NUM_RD  pending-producer flag per port; rd_tag  out  NUM_RD*TAG_W  producer tag per port; commit_en  in  1  ROB commits a result; commit_rd  in  5  committed register; commit_tag  in  TAG_W  committed tag; commit_data  in  DATA_W  committed value; ckpt_take  in  1  snapshot rename table (branch dispatch); ckpt_id  out  log2(NUM_CKPT)  slot the next take will use; ckpt_full  out  1  no free slot; ckpt_release  in  1  free oldest slot (branch resolved correct); restore_en  in  1  mispredict recovery; restore_id  in  log2(NUM_CKPT)  slot to restore; flush  in  1  full pipeline flush.

Function
REQ-003 SHALL hold per register a value (DATA_W), busy bit and tag (TAG_W); all state updates on rising clk, visible to reads the following cycle.
REQ-004 SHALL read combinationally: rd_data = value, rd_busy = busy, rd_tag = tag of rd_addr, reflecting state before this cycle's rename.
REQ-005 SHALL bypass commit to reads: commit_en with commit_rd == rd_addr != 0 -> rd_data = commit_data; additionally if stored tag == commit_tag -> rd_busy = 0.
REQ-006 SHALL force rd_data = 0, rd_busy = 0, rd_tag = 0 for rd_addr == 0; rename or commit to x0 SHALL be ignored.
REQ-007 SHALL on commit write value unconditionally, clear busy only if busy and stored tag == commit_tag (younger rename not lost).
REQ-008 SHALL on rename_en set busy=1, tag=rename_tag for rename_rd; same-cycle commit to same register SHALL write value but NOT clear busy.
REQ-009 SHALL manage checkpoints as a circular FIFO (head = oldest, tail = ckpt_id, count 0..NUM_CKPT); ckpt_full = (count == NUM_CKPT).
REQ-010 SHALL on ckpt_take with !ckpt_full copy busy/tag tables, including this cycle's commit clear and rename, into slot tail; tail+1 mod NUM_CKPT; count+1; take while full ignored.
REQ-011 SHALL on ckpt_release with count>0 advance head, count-1; release when empty ignored; take+release same cycle: count unchanged, both pointers advance.
REQ-012 SHALL on every commit also clear busy in each live slot whose entry for commit_rd is busy with tag == commit_tag.
REQ-013 SHALL on restore_en with restore_id live load busy/tag from that slot (then apply same-cycle commit clear), set tail = restore_id, count = restore_id - head (mod), discarding it and younger; restore_id not live ignored.
REQ-014 SHALL on flush clear all busy bits, head = tail = 0, count = 0; values retained.
REQ-015 SHALL prioritise flush > restore_en > (rename_en, ckpt_take, ckpt_release); commit value write never suppressed.

Reset
REQ-016 SHALL on rst low asynchronously clear all values, busy bits, tags, slots, head, tail, count; outputs: rd_busy 0, rd_tag 0, rd_data 0, ckpt_id 0, ckpt_full 0.
REQ-017 SHALL resume normal operation on first rising clk after rst deasserts; reset mid-operation discards all checkpoints.

Configuration
REQ-018 SHALL implement checkpointing only when RF_CKPT_EN defined; undefined: slots, pointers absent, ckpt_full = 0, ckpt_id = 0, ckpt_take/ckpt_release ignored, restore_en behaves as flush (clear all busy).

Verification
REQ-019 SHALL cover: rename x5 tag 3, next cycle read x5 -> busy 1, tag 3; commit x5 tag 3 data 0xDEAD -> same-cycle read busy 0, data 0xDEAD.
REQ-020 SHALL cover: rename x7 tag 2 then x7 tag 6; commit x7 tag 2 data 0x11 -> x7 value 0x11, busy 1, tag 6.
REQ-021 SHALL cover: rename x3 tag 1, ckpt_take (id 0), rename x3 tag 4, restore_id 0 -> x3 busy 1 tag 1, ckpt_id 0, count 0.
REQ-022 SHALL cover: four takes with NUM_CKPT=4 -> ckpt_full 1; fifth take ignored; one release -> ckpt_full 0, ckpt_id wraps 0.
REQ-023 SHALL cover: checkpoint holds x9 tag 5, commit x9 tag 5, then restore -> x9 busy 0; flush with rename same cycle -> all busy 0; rename/read x0 -> data 0, busy 0.
